// File: rtl/mcb_port_arbiter.sv
// rtl/mcb_port_arbiter.sv - two-requester burst arbiter/sequencer for MIG user port p0
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module mcb_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int BL_W   = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_calib_done,
  input  logic [1:0]            i_req,
  input  logic [1:0]            i_req_wr,
  input  logic [2*ADDR_W-1:0]   i_req_addr,
  input  logic [2*BL_W-1:0]     i_req_bl,
  output logic [1:0]            o_gnt,
  output logic [1:0]            o_done,
  input  logic [2*DATA_W-1:0]   i_w_data,
  input  logic [1:0]            i_w_valid,
  output logic [1:0]            o_w_ready,
  output logic [DATA_W-1:0]     o_r_data,
  output logic [1:0]            o_r_valid,
  output logic                  o_cmd_en,
  output logic [2:0]            o_cmd_instr,
  output logic [BL_W-1:0]       o_cmd_bl,
  output logic [ADDR_W-1:0]     o_cmd_byte_addr,
  input  logic                  i_cmd_full,
  output logic                  o_wr_en,
  output logic [DATA_W-1:0]     o_wr_data,
  output logic [3:0]            o_wr_mask,
  input  logic                  i_wr_full,
  output logic                  o_rd_en,
  input  logic [DATA_W-1:0]     i_rd_data,
  input  logic                  i_rd_empty
);

  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WCMD, S_RCMD, S_RDATA} state_t;

  state_t              r_state, w_next;
  logic                r_owner;
  logic [ADDR_W-1:0]   r_addr;
  logic [BL_W-1:0]     r_bl;
  logic [BL_W:0]       r_cnt;
  logic                r_last;
  logic [1:0]          r_r_valid;
  logic [DATA_W-1:0]   r_r_data;

  logic                w_win;
  logic                w_start;
  logic [1:0]          w_owner_oh;
  logic                w_wbeat;
  logic                w_rd_fire;
  logic                w_cnt_at_bl;

`ifdef ARB_FIXED_PRIO_EN
  assign w_win = ~i_req[0];
`else
  // Pointer holds the last-served requester; it loses when both request.
  logic r_last_srv;
  assign w_win = (&i_req) ? ~r_last_srv : i_req[1];
`endif

  assign w_start     = (r_state == S_IDLE) & i_calib_done & (|i_req);
  assign w_owner_oh  = r_owner ? 2'b10 : 2'b01;
  assign w_cnt_at_bl = (r_cnt == {1'b0, r_bl});
  assign w_wbeat     = (r_state == S_WDATA) & i_w_valid[r_owner] & ~i_wr_full;
  assign w_rd_fire   = (r_state == S_RDATA) & ~i_rd_empty & (r_cnt <= {1'b0, r_bl});

  assign o_r_data  = r_r_data;
  assign o_r_valid = r_r_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_owner   <= 1'b0;
      r_addr    <= '0;
      r_bl      <= '0;
      r_cnt     <= '0;
      r_last    <= 1'b0;
      r_r_valid <= 2'b00;
      r_r_data  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last_srv <= 1'b1;
`endif
    end else begin
      r_state   <= w_next;
      r_r_valid <= w_rd_fire ? w_owner_oh : 2'b00;
      r_last    <= w_rd_fire & w_cnt_at_bl;
      if (w_start) begin
        r_owner <= w_win;
        r_addr  <= w_win ? i_req_addr[2*ADDR_W-1:ADDR_W] : i_req_addr[ADDR_W-1:0];
        r_bl    <= w_win ? i_req_bl[2*BL_W-1:BL_W] : i_req_bl[BL_W-1:0];
        r_cnt   <= '0;
`ifndef ARB_FIXED_PRIO_EN
        r_last_srv <= w_win;
`endif
      end else if (w_wbeat || w_rd_fire) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_rd_fire) begin
        r_r_data <= i_rd_data;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    o_gnt           = (r_state == S_IDLE) ? 2'b00 : w_owner_oh;
    o_done          = 2'b00;
    o_w_ready       = 2'b00;
    o_cmd_en        = 1'b0;
    o_cmd_instr     = 3'b000;
    o_cmd_bl        = '0;
    o_cmd_byte_addr = '0;
    o_wr_en         = 1'b0;
    o_wr_data       = '0;
    o_wr_mask       = 4'b0000;
    o_rd_en         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = i_req_wr[w_win] ? S_WDATA : S_RCMD;
        end
      end
      S_WDATA: begin
        o_wr_en   = w_wbeat;
        o_w_ready = w_wbeat ? w_owner_oh : 2'b00;
        o_wr_data = r_owner ? i_w_data[2*DATA_W-1:DATA_W] : i_w_data[DATA_W-1:0];
        if (w_wbeat && w_cnt_at_bl) begin
          w_next = S_WCMD;
        end
      end
      S_WCMD: begin
        o_cmd_bl        = r_bl;
        o_cmd_byte_addr = r_addr & ~ADDR_W'(3);
        if (!i_cmd_full) begin
          o_cmd_en = 1'b1;
          o_done   = w_owner_oh;
          w_next   = S_IDLE;
        end
      end
      S_RCMD: begin
        o_cmd_instr     = 3'b001;
        o_cmd_bl        = r_bl;
        o_cmd_byte_addr = r_addr & ~ADDR_W'(3);
        if (!i_cmd_full) begin
          o_cmd_en = 1'b1;
          w_next   = S_RDATA;
        end
      end
      S_RDATA: begin
        o_rd_en = w_rd_fire;
        // r_last rides alongside the final registered r_valid beat.
        if (r_last) begin
          o_done = w_owner_oh;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// tb/tb_mcb_port_arbiter.sv - scoreboard bench for mcb_port_arbiter
module tb_mcb_port_arbiter;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = 6;

  logic clk = 1'b0;
  logic rst, calib;
  logic [1:0] req, req_wr, gnt, done, w_valid, w_ready, r_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*BW-1:0] req_bl;
  logic [2*DW-1:0] w_data;
  logic [DW-1:0] r_data, wr_data, rd_data;
  logic cmd_en, cmd_full, wr_en, wr_full, rd_en, rd_empty;
  logic [2:0] cmd_instr;
  logic [BW-1:0] cmd_bl;
  logic [AW-1:0] cmd_addr;
  logic [3:0] wr_mask;
  logic [117:0] outs;

  always #5 clk = ~clk;

  mcb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BL_W(BW)) dut (
    .i_clk(clk), .i_reset(rst), .i_calib_done(calib),
    .i_req(req), .i_req_wr(req_wr), .i_req_addr(req_addr), .i_req_bl(req_bl),
    .o_gnt(gnt), .o_done(done),
    .i_w_data(w_data), .i_w_valid(w_valid), .o_w_ready(w_ready),
    .o_r_data(r_data), .o_r_valid(r_valid),
    .o_cmd_en(cmd_en), .o_cmd_instr(cmd_instr), .o_cmd_bl(cmd_bl),
    .o_cmd_byte_addr(cmd_addr), .i_cmd_full(cmd_full),
    .o_wr_en(wr_en), .o_wr_data(wr_data), .o_wr_mask(wr_mask), .i_wr_full(wr_full),
    .o_rd_en(rd_en), .i_rd_data(rd_data), .i_rd_empty(rd_empty)
  );

  assign outs = {gnt, done, w_ready, r_data, r_valid, cmd_en, cmd_instr, cmd_bl,
                 cmd_addr, wr_en, wr_data, wr_mask, rd_en};

  int n_cmp = 0, n_err = 0;
  int n_wr = 0, n_cmd = 0, n_done = 0, n_rv0 = 0, n_rv1 = 0;
  int cyc = 0, wsel = 0;
  bit wfixed = 0, rgap = 0, prev_done = 0;
  logic [1:0] rown = 2'b00;
  logic [DW-1:0] wbeats[$];
  logic [DW-1:0] rq[$];
  logic [DW-1:0] exp_wr[$];
  logic [38:0] exp_cmd[$];
  logic [33:0] exp_rd[$];
  logic [2:0] exp_done[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (!wfixed) begin
      w_valid = 2'b00;
      w_data  = '0;
      if (wbeats.size() > 0) begin
        w_valid[wsel] = 1'b1;
        w_data[wsel*DW +: DW] = wbeats[0];
      end
    end
    rd_data  = (rq.size() > 0) ? rq[0] : '0;
    rd_empty = (rq.size() == 0) || (rgap && (cyc % 4 == 2));
  endtask

  // One clock: sample and score DUT outputs at negedge, then advance the bench-side FIFOs.
  task automatic tick();
    logic s_wr, s_rd;
    logic [DW-1:0] s_rdd;
    logic [2:0] e;
    drive();
    @(negedge clk);
    if (prev_done) chk("idle_gap", gnt, 0);
    prev_done = (done != 2'b00);
    s_wr = wr_en; s_rd = rd_en; s_rdd = rd_data;
    if (wr_en) begin
      n_wr++;
      if (exp_wr.size() == 0) chk("wr_unexpected", wr_en, 0);
      else chk("wr_beat", {wr_mask, wr_data}, {4'b0000, exp_wr.pop_front()});
    end
    if (cmd_en) begin
      n_cmd++;
      if (exp_cmd.size() == 0) chk("cmd_unexpected", cmd_en, 0);
      else chk("cmd", {cmd_instr, cmd_bl, cmd_addr}, exp_cmd.pop_front());
    end
    if (r_valid != 2'b00) begin
      if (r_valid[0]) n_rv0++;
      if (r_valid[1]) n_rv1++;
      if (exp_rd.size() == 0) chk("rd_unexpected", r_valid, 0);
      else chk("rd_beat", {r_valid, r_data}, exp_rd.pop_front());
    end
    if (done != 2'b00) begin
      n_done++;
      if (exp_done.size() == 0) chk("done_unexpected", done, 0);
      else begin
        e = exp_done.pop_front();
        chk("done", done, e[1:0]);
        if (e[2]) chk("done_with_last_rvalid", r_valid, e[1:0]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_wr && !wfixed && wbeats.size() > 0) wbeats.delete(0);
    if (s_rd) begin
      if (rq.size() > 0) rq.delete(0);
      exp_rd.push_back({rown, s_rdd});
    end
  endtask

  task automatic run_until_done(input int budget, input string tag);
    int start, k;
    start = n_done;
    k = 0;
    while (n_done == start && k < budget) begin
      tick();
      k++;
    end
    chk({tag, "_done_seen"}, (n_done != start), 1);
  endtask

  task automatic sb_empty(input string tag);
    chk(tag, exp_wr.size() + exp_cmd.size() + exp_done.size() + exp_rd.size(), 0);
  endtask

  initial begin
    int w0, c0, r0, r1, k, g;
    rst = 1; calib = 1; req = 0; req_wr = 0; req_addr = '0; req_bl = '0;
    w_valid = 0; w_data = '0; cmd_full = 0; wr_full = 0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", outs, 0);
    rst = 0;
    tick();
    chk("idle_outputs", outs, 0);

    // Single write: 4 beats to 0x104
    wsel = 0;
    for (int i = 0; i < 4; i++) begin
      wbeats.push_back(32'hA0 + i);
      exp_wr.push_back(32'hA0 + i);
    end
    exp_cmd.push_back({3'b000, 6'd3, 30'h104});
    exp_done.push_back({1'b0, 2'b01});
    req_wr = 2'b01; req_addr[AW-1:0] = 30'h104; req_bl[BW-1:0] = 6'd3;
    req = 2'b01;
    w0 = n_wr; c0 = n_cmd;
    #1;
    chk("gnt_before_edge", gnt, 0);
    tick();
    chk("gnt_latency", gnt, 2'b01);
    run_until_done(50, "wr1");
    req = 0;
    chk("wr1_beats", n_wr - w0, 4);
    chk("wr1_cmds", n_cmd - c0, 1);
    sb_empty("wr1_scoreboard");

    // wr_full stall mid-burst; low address bits must be cleared on the command
    for (int i = 0; i < 8; i++) begin
      wbeats.push_back(32'hB0 + i);
      exp_wr.push_back(32'hB0 + i);
    end
    exp_cmd.push_back({3'b000, 6'd7, 30'h200});
    exp_done.push_back({1'b0, 2'b01});
    req_addr[AW-1:0] = 30'h203; req_bl[BW-1:0] = 6'd7;
    req = 2'b01;
    w0 = n_wr;
    k = 0;
    while (n_wr - w0 < 2 && k < 20) begin tick(); k++; end
    wr_full = 1;
    repeat (5) begin
      #1;
      chk("stall_w_ready", w_ready, 0);
      chk("stall_wr_en", wr_en, 0);
      tick();
    end
    chk("stall_beats_held", n_wr - w0, 2);
    wr_full = 0;
    #1;
    chk("w_ready_resume", w_ready, 2'b01);
    run_until_done(60, "wr2");
    req = 0;
    chk("wr2_beats", n_wr - w0, 8);
    sb_empty("wr2_scoreboard");

    // Read bl 15 for requester 1 with gaps in rd_empty
    rown = 2'b10; rgap = 1;
    for (int i = 0; i < 16; i++) rq.push_back(32'hC000_0000 + i * 32'h111);
    exp_cmd.push_back({3'b001, 6'd15, 30'h1000});
    exp_done.push_back({1'b1, 2'b10});
    req_wr = 2'b00; req_addr[2*AW-1:AW] = 30'h1000; req_bl[2*BW-1:BW] = 6'd15;
    req = 2'b10;
    r0 = n_rv0; r1 = n_rv1;
    run_until_done(200, "rd");
    req = 0; rgap = 0;
    chk("rd_rvalid1_count", n_rv1 - r1, 16);
    chk("rd_rvalid0_count", n_rv0 - r0, 0);
    chk("rd_fifo_drained", rq.size(), 0);
    sb_empty("rd_scoreboard");

    // Contention: both write, bl 0, held for four transactions
    wfixed = 1; w_valid = 2'b11; w_data = {32'hD1, 32'hD0};
    req_wr = 2'b11; req_addr = {30'h40, 30'h80}; req_bl = '0;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = i % 2;
`endif
      exp_wr.push_back(g == 0 ? 32'hD0 : 32'hD1);
      exp_cmd.push_back({3'b000, 6'd0, (g == 0 ? 30'h80 : 30'h40)});
      exp_done.push_back({1'b0, (g == 0 ? 2'b01 : 2'b10)});
    end
    req = 2'b11;
    repeat (4) run_until_done(30, "contention");
    req = 0; wfixed = 0;
    sb_empty("contention_scoreboard");

    // Calibration gate
    calib = 0;
    wbeats.push_back(32'hE0); exp_wr.push_back(32'hE0);
    exp_cmd.push_back({3'b000, 6'd0, 30'h10});
    exp_done.push_back({1'b0, 2'b01});
    req_wr = 2'b01; req_addr = '0; req_addr[AW-1:0] = 30'h10; req_bl = '0;
    req = 2'b01;
    repeat (20) begin
      tick();
      chk("calib_gate_gnt", gnt, 0);
    end
    calib = 1;
    tick();
    chk("calib_gnt_latency", gnt, 2'b01);
    run_until_done(30, "calib");
    req = 0;
    sb_empty("calib_scoreboard");

    // Reset after 2 of 8 beats
    for (int i = 0; i < 8; i++) wbeats.push_back(32'hF0 + i);
    exp_wr.push_back(32'hF0); exp_wr.push_back(32'hF1);
    req_addr[AW-1:0] = 30'h300; req_bl[BW-1:0] = 6'd7;
    req = 2'b01;
    w0 = n_wr;
    k = 0;
    while (n_wr - w0 < 2 && k < 20) begin tick(); k++; end
    rst = 1;
    #1;
    chk("reset_mid_burst_outputs", outs, 0);
    req = 0;
    wbeats.delete();
    tick();
    chk("reset_held_outputs", outs, 0);
    rst = 0;
    tick();
    chk("post_reset_idle", outs, 0);
    sb_empty("reset_scoreboard");

    // Transaction after reset starts cleanly from IDLE
    wbeats.push_back(32'h99); exp_wr.push_back(32'h99);
    exp_cmd.push_back({3'b000, 6'd0, 30'h8});
    exp_done.push_back({1'b0, 2'b01});
    req_addr[AW-1:0] = 30'h8; req_bl = '0;
    req = 2'b01;
    run_until_done(30, "post_reset_wr");
    req = 0;
    tick();
    sb_empty("final_scoreboard");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mcb_port_arbiter.md
# mcb_port_arbiter

Two-requester arbiter and sequencer for a single MIG user port (p0): the host DMA path and the accelerator engine share the DDR2 command, write and read FIFOs. The block grants one requester per burst transaction. It steers write beats into the MCB write FIFO before issuing the write command, and steers read beats back to the owner after issuing the read command. It sits between the requesters and the `mem_ctrl` p0 port, in the `c3_clk0` domain.

## Interface
- `ADDR_W`, 30, MCB byte-address width
- `DATA_W`, 32, user data port width
- `BL_W`, 6, burst-length field width (value = words − 1)
- `clk` in 1: `c3_clk0` domain clock
- `reset` in 1: asynchronous, active-high
- `calib_done` in 1: MCB calibration complete; no grant while low
- `req` in 2: per-requester transaction request, level, held until `done`
- `req_wr` in 2: per-requester direction, 1 = write, 0 = read
- `req_addr` in 2×`ADDR_W`: byte address; requester i occupies bits [i*ADDR_W +: ADDR_W]
- `req_bl` in 2×`BL_W`: burst length − 1, packed the same way
- `gnt` out 2: one-hot grant, held for the whole transaction
- `done` out 2: one-cycle pulse at transaction end
- `w_data` in 2×`DATA_W`: write beat from each requester
- `w_valid` in 2: write beat valid
- `w_ready` out 2: write beat accepted this cycle
- `r_data` out `DATA_W`: shared read-return data
- `r_valid` out 2: read beat valid for requester i
- `cmd_en` out 1: to MCB p0
- `cmd_instr` out 3: to MCB p0
- `cmd_bl` out `BL_W`: to MCB p0
- `cmd_byte_addr` out `ADDR_W`: to MCB p0
- `cmd_full` in 1: from MCB p0
- `wr_en` out 1: to MCB p0
- `wr_data` out `DATA_W`: to MCB p0
- `wr_mask` out 4: to MCB p0
- `wr_full` in 1: from MCB p0
- `rd_en` out 1: to MCB p0
- `rd_data` in `DATA_W`: from MCB p0
- `rd_empty` in 1: from MCB p0

## Operation
- States: IDLE, WDATA, WCMD, RCMD, RDATA.
- **IDLE**
  - When `calib_done` = 1 and any `req` bit is set, pick a winner: round-robin, where the last-served requester loses ties.
  - Latch the winner's addr, bl and dir; assert `gnt`; go to WDATA (write) or RCMD (read).
- **WDATA**
  - `w_ready[g] = w_valid[g] & ~wr_full`; `wr_en` = that same term.
  - `wr_data = w_data[g]`; `wr_mask` = 4'b0000.
  - A beat counter runs 0..bl. When beat bl is accepted, go to WCMD.
- **WCMD**
  - Pulse `cmd_en` for one cycle with `cmd_full` = 0, `cmd_instr` = 3'b000, `cmd_bl` = latched bl, `cmd_byte_addr` = latched addr with [1:0] forced to 0.
  - Same cycle: pulse `done[g]` and drop `gnt`. Go to IDLE.
- **RCMD**
  - Pulse `cmd_en` (`cmd_instr` = 3'b001) when `cmd_full` = 0, then go to RDATA.
- **RDATA**
  - `rd_en = ~rd_empty`.
  - `r_data` is registered from `rd_data`. `r_valid[g]` is asserted the cycle after each `rd_en`; the requester cannot stall.
  - After bl+1 beats: pulse `done[g]` with the last `r_valid`, drop `gnt`, go to IDLE.
- Counter width is `BL_W` + 1. bl = 63 gives 64 beats with no wrap.
- `req` changes while granted are ignored; the latched values are used.
- `calib_done` falling mid-transaction does not abort it; it only blocks new grants.

## Timing
- Reset values: all outputs 0; state IDLE; round-robin pointer favours requester 0.
- Grant latency: 1 cycle from `req` sampled in IDLE to `gnt` high.
- Write turnaround: last beat accepted → `cmd_en` the next cycle, provided `cmd_full` = 0.
- Read: `cmd_en` → `rd_en` when `rd_empty` falls; `rd_en` → `r_valid` 1 cycle.
- Back-to-back transactions: there is at least 1 IDLE cycle between `done` and the next `gnt`.
- `cmd_en`, `wr_en` and `rd_en` are never asserted during `reset` or in IDLE.
- Reset mid-transaction returns immediately to IDLE. Beats already in the MCB FIFOs are not flushed; the system resets the MCB together with this block.

## Configuration
- `ARB_FIXED_PRIO_EN` defined: fixed priority, requester 0 always wins simultaneous requests, no pointer register.
- Not defined: round-robin as described above.

## Test plan
- Single write: req0 write, addr 0x104, bl 3, four beats 0xA0..0xA3. Required: `wr_en` ×4 then `cmd_en` with addr 0x104, bl 3, instr 000; `done[0]` ×1.
- `wr_full` stall: write bl 7 with `wr_full` high for 5 cycles mid-burst. Required: `w_ready` low during the stall, exactly 8 `wr_en`, no lost data.
- Read return: req1 read bl 15, MCB delivers 16 words with gaps in `rd_empty`. Required: 16 `r_valid[1]` in order, `r_valid[0]` never set, `done[1]` coincident with the 16th.
- Contention: req0 and req1 held continuously. Required: grants alternate 0,1,0,1 (or always 0 with `ARB_FIXED_PRIO_EN`).
- Calibration gate: `calib_done` = 0 with req0 high for 20 cycles. Required: no `gnt`; grant 1 cycle after `calib_done` rises.
- Reset mid-burst: assert `reset` after 2 of 8 write beats. Required: all outputs 0 immediately, state IDLE.
